beep_pattern_ctrl: RTL
======================

Name: beep_pattern_ctrl

Overview:
- Successor to the single-key beep toggle. Takes debounced key events for three keys and drives the buzzer in one of three modes: continuous alarm, timed burst of N beeps, or silence.
- Optional square-wave tone output supports a passive buzzer.
- Sits between the key debounce blocks and the buzzer pin in the top-level key/beep design.

Parameters:
- ON_CYC, 25000000, beep-on duration per burst beep, in sys_clk cycles (≥1).
- OFF_CYC, 25000000, gap between burst beeps, in cycles (≥1).
- BURST_CNT, 3, beeps per burst (1..255).
- TONE_DIV, 0, 0 = DC drive (active buzzer); >0 = beep toggles every TONE_DIV cycles while sounding.
- CNT_W, 25, timer width; must hold max(ON_CYC, OFF_CYC, TONE_DIV).

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous reset, active-high
- key_flag  in  3  one-cycle debounce-valid strobe per key
- key_value  in  3  debounced key level per key, active-low (0 = pressed)
- beep  out  1  buzzer drive, active-low (0 = sounding)
- busy  out  1  1 when not IDLE
- burst_done  out  1  one-cycle pulse when a burst completes naturally

Behaviour:
- Interface: one clock, sys_clk. Reset is sys_rst, synchronous and active-high. All state changes occur on the rising edge of sys_clk.
- Press event i: key_flag[i] && !key_value[i]. Keys: 0 = alarm toggle, 1 = burst start, 2 = stop.
- Reset: state IDLE, timers and counters 0. Outputs: beep=1, busy=0, burst_done=0. Reset overrides everything, including a press in the same cycle.
- States: IDLE, CONT, B_ON, B_OFF. Same-cycle press priority: key2 > key0 > key1.
- IDLE:
  - key0 → CONT.
  - key1 → B_ON with beep_idx=1, timer=0.
- CONT:
  - key0 or key2 → IDLE.
  - key1 ignored.
- B_ON / B_OFF:
  - key2 → IDLE. No burst_done.
  - key0 → CONT.
  - key1 → restart: B_ON, beep_idx=1, timer=0.
- B_ON timing: timer increments each cycle. At timer==ON_CYC-1 → B_OFF, timer=0.
- B_OFF timing: at timer==OFF_CYC-1:
  - beep_idx==BURST_CNT → IDLE, burst_done=1 for that cycle.
  - Otherwise → B_ON, beep_idx+1, timer=0.
- Each ON state lasts exactly ON_CYC cycles and each OFF state exactly OFF_CYC cycles. A burst therefore occupies BURST_CNT*(ON_CYC+OFF_CYC) cycles, including the final OFF gap.
- beep and busy are registered from next-state. The edge that samples a press also updates the outputs, giving 1-cycle latency from the press strobe.
- Sounding states are CONT and B_ON.
  - TONE_DIV=0: beep=0 when sounding, else 1.
  - TONE_DIV>0: on entry to a sounding state, beep=0 and the tone counter clears. beep then inverts every TONE_DIV cycles. The tone counter clears on every B_ON entry.
- Non-sounding states always force beep=1.
- Events with key_value high (releases) are ignored. A key_flag without the flag is ignored regardless of key_value.
- Counters never wrap. The timer is cleared on every state change.

Test Plan:
(All with ON_CYC=4, OFF_CYC=2, BURST_CNT=3, TONE_DIV=0 unless stated.)
- Reset: hold sys_rst 3 cycles while pulsing key0 → beep=1, busy=0 throughout. First press after release is accepted normally.
- Alarm toggle: key0 press → beep=0 and busy=1 the next cycle, held indefinitely. A key1 press meanwhile changes nothing. A second key0 press → beep=1, busy=0 the next cycle. A key0 event with key_value=1 → no change.
- Burst: key1 press → beep pattern 0000 11 0000 11 0000 11 (18 cycles). burst_done pulses exactly once on the 18th cycle edge, then busy=0.
- Cancel/retrigger: key2 press in the 2nd beep → beep=1 and IDLE next cycle, no burst_done. Separately, key1 during the 2nd B_OFF → burst restarts, giving 3 further beeps.
- Priority: key0, key1 and key2 pressed in the same cycle from CONT → IDLE. key0 and key1 pressed together from IDLE → CONT.
- Tone: TONE_DIV=2, key0 press → beep sequence 0,0,1,1,0,0,… Stop → beep=1 immediately.

Source files
------------

// File: rtl/beep_pattern_ctrl_if.sv
// Key-event inputs and buzzer/status outputs of beep_pattern_ctrl.
// master = key debounce side, slave = the controller.
interface beep_pattern_ctrl_if;
  logic [2:0] key_flag;
  logic [2:0] key_value;
  logic       beep;
  logic       busy;
  logic       burst_done;

  modport master (output key_flag, key_value, input beep, busy, burst_done);
  modport slave  (input key_flag, key_value, output beep, busy, burst_done);
endinterface

// File: rtl/beep_pattern_ctrl.sv
// Buzzer pattern controller: continuous alarm, timed N-beep burst, or silence.
// Outputs are registered from next-state, so a press shows one cycle after its strobe.
module beep_pattern_ctrl #(
  parameter int ON_CYC    = 25000000,
  parameter int OFF_CYC   = 25000000,
  parameter int BURST_CNT = 3,
  parameter int TONE_DIV  = 0,
  parameter int CNT_W     = 25
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  beep_pattern_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONT, B_ON, B_OFF} state_t;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] TONE_LAST  = CNT_W'((TONE_DIV > 0) ? TONE_DIV - 1 : 0);
  localparam logic [7:0]       BURST_LAST = 8'(BURST_CNT);

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] tone_cnt, tone_cnt_n;
  logic [7:0]       beep_idx, idx_n;
  logic [2:0]       press;
  logic             restart, entry, snd_n, done_n, beep_n;

  always_comb begin
    press   = bus.key_flag & ~bus.key_value;
    state_n = state;
    idx_n   = beep_idx;
    restart = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (press[0]) state_n = CONT;
        else if (press[1]) begin
          state_n = B_ON;
          idx_n   = 8'd1;
        end
      end
      CONT: if (press[0] || press[2]) state_n = IDLE;
      B_ON, B_OFF: begin
        if (press[2]) state_n = IDLE;
        else if (press[0]) state_n = CONT;
        else if (press[1]) begin
          state_n = B_ON;
          idx_n   = 8'd1;
          restart = 1'b1;
        end else if (state == B_ON && timer == ON_LAST) state_n = B_OFF;
        else if (state == B_OFF && timer == OFF_LAST) begin
          if (beep_idx == BURST_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = B_ON;
            idx_n   = beep_idx + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Restart re-enters B_ON from B_ON, so it counts as an entry too.
    entry   = restart || (state_n != state);
    timer_n = (entry || !(state_n == B_ON || state_n == B_OFF)) ? '0 : timer + 1'b1;
    snd_n   = (state_n == CONT) || (state_n == B_ON);

    tone_cnt_n = '0;
    if (!snd_n)             beep_n = 1'b1;
    else if (TONE_DIV == 0) beep_n = 1'b0;
    else if (entry)         beep_n = 1'b0;
    else if (tone_cnt == TONE_LAST) beep_n = ~bus.beep;
    else begin
      beep_n     = bus.beep;
      tone_cnt_n = tone_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state          <= IDLE;
      timer          <= '0;
      tone_cnt       <= '0;
      beep_idx       <= '0;
      bus.beep       <= 1'b1;
      bus.busy       <= 1'b0;
      bus.burst_done <= 1'b0;
    end else begin
      state          <= state_n;
      timer          <= timer_n;
      tone_cnt       <= tone_cnt_n;
      beep_idx       <= idx_n;
      bus.beep       <= beep_n;
      bus.busy       <= (state_n != IDLE);
      bus.burst_done <= done_n;
    end
  end

endmodule
